mem_host_bridge: RTL and testbench
==================================

MEM_HOST_BRIDGE -- requirements
Module: mem_host_bridge

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- cfg_base_valid  in  1  one-cycle pulse, host buffer base address valid
- cfg_base_addr  in  64  byte address of host buffer, bits[5:0] ignored
- address  in  32  cache-line index relative to base, from control unit
- write_data  in  512  line to write, from control unit
- read_request_valid  in  1  level; held by control unit until data_valid
- write_request_valid  in  1  level; held by control unit until write_done
- buffer_addr_valid  out  1  base address latched, bridge usable
- data_valid  out  1  one-cycle read-completion pulse
- read_data  out  512  returned line, valid with data_valid
- write_done  out  1  one-cycle write-completion pulse
- rd_req_valid  out  1  host read request
- rd_req_addr  out  58  host cache-line address
- rd_req_ready  in  1  host accepts read request
- rd_rsp_valid  in  1  host read response
- rd_rsp_data  in  512  host read response line
- wr_req_valid  out  1  host write request
- wr_req_addr  out  58  host cache-line address
- wr_req_data  out  512  host write line
- wr_req_ready  in  1  host accepts write request
- wr_rsp_valid  in  1  host write acknowledge
- busy  out  1  state not IDLE
- stray_rsp  out  1  sticky: response received while no request outstanding
- rd_count  out  32  completed reads, wraps
- wr_count  out  32  completed writes, wraps
REQ-002 SHALL use one clock, clk; reset rst synchronous, active-high.

Function
REQ-003 SHALL latch base_line = cfg_base_addr[63:6] on cfg_base_valid; buffer_addr_valid high from next cycle until reset; later pulses overwrite base_line only in IDLE, ignored otherwise.
REQ-004 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, CMPL; one request outstanding max.
REQ-005 IDLE: requests ignored while buffer_addr_valid low; otherwise read_request_valid -> RD_REQ, else write_request_valid -> WR_REQ; both high -> read wins.
REQ-006 On leaving IDLE SHALL register host address = base_line + zero-extended address (58-bit, modulo 2^58) and, for writes, write_data.
REQ-007 RD_REQ: rd_req_valid high, address stable; rd_req_valid && rd_req_ready -> RD_WAIT. WR_REQ analogous with wr_req_valid/wr_req_ready -> WR_WAIT.
REQ-008 RD_WAIT: rd_rsp_valid -> register rd_rsp_data into read_data, go CMPL. WR_WAIT: wr_rsp_valid -> CMPL. Response same cycle as request acceptance not possible and SHALL be treated as stray.
REQ-009 CMPL: exactly one cycle; data_valid (read) or write_done (write) high; matching counter increments by 1 (wrapping 0xFFFFFFFF -> 0); requests ignored; next state IDLE.
REQ-010 Latency: request seen in IDLE at cycle t -> host valid at t+1; host response at cycle u -> completion pulse at u+1.
REQ-011 read_data SHALL hold last returned line until next read response.
REQ-012 rd_rsp_valid outside RD_WAIT or wr_rsp_valid outside WR_WAIT SHALL be dropped and set stray_rsp; no state change.
REQ-013 Request deasserted mid-transaction SHALL not abort it; completion pulse still issued.

Reset
REQ-014 rst SHALL force IDLE; buffer_addr_valid, data_valid, write_done, rd_req_valid, wr_req_valid, busy, stray_rsp low; read_data, rd_req_addr, wr_req_addr, wr_req_data, base_line, rd_count, wr_count zero.
REQ-015 rst mid-transaction SHALL abandon it; late host response after reset SHALL set stray_rsp, produce no completion pulse.

Verification
REQ-016 Base 0x1000, address 3, read, rd_req_ready tied 1, response 0xA5.. after 4 cycles -> rd_req_addr 0x43, data_valid one cycle, read_data 0xA5.., rd_count 1.
REQ-017 read_request_valid and write_request_valid both high -> read issued first; write issued after CMPL only if still held; wr_count 1 after write_done.
REQ-018 Request before cfg_base_valid -> no host activity, busy low; after base pulse -> request serviced.
REQ-019 rd_req_ready low 10 cycles -> rd_req_valid and rd_req_addr stable all 10 cycles; accepted on cycle 11.
REQ-020 wr_rsp_valid while IDLE -> stray_rsp set and sticky, no write_done; rst clears it.
REQ-021 rst asserted in RD_WAIT then rd_rsp_valid -> no data_valid, rd_count 0, stray_rsp 1, buffer_addr_valid 0.

Source files
------------

// File: rtl/mem_host_bridge.sv
// Bridge from a control unit's line read/write requests to a host memory
// request/response channel, relative to a host buffer base address.
module mem_host_bridge (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_base_valid,
    input  logic [63:0]  cfg_base_addr,
    input  logic [31:0]  address,
    input  logic [511:0] write_data,
    input  logic         read_request_valid,
    input  logic         write_request_valid,
    output logic         buffer_addr_valid,
    output logic         data_valid,
    output logic [511:0] read_data,
    output logic         write_done,
    output logic         rd_req_valid,
    output logic [57:0]  rd_req_addr,
    input  logic         rd_req_ready,
    input  logic         rd_rsp_valid,
    input  logic [511:0] rd_rsp_data,
    output logic         wr_req_valid,
    output logic [57:0]  wr_req_addr,
    output logic [511:0] wr_req_data,
    input  logic         wr_req_ready,
    input  logic         wr_rsp_valid,
    output logic         busy,
    output logic         stray_rsp,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        CMPL
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [57:0] base_line;
    logic [57:0] host_line;
    logic        txn_is_read;
    logic        start_read;
    logic        start_write;

    // 58-bit sum wraps modulo 2^58 by construction
    assign host_line   = base_line + {26'd0, address};
    assign start_read  = (state == IDLE) && buffer_addr_valid && read_request_valid;
    assign start_write = (state == IDLE) && buffer_addr_valid && !read_request_valid
                         && write_request_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_read) begin
                    next_state = RD_REQ;
                end else if (start_write) begin
                    next_state = WR_REQ;
                end
            end
            RD_REQ:  if (rd_req_ready) next_state = RD_WAIT;
            RD_WAIT: if (rd_rsp_valid) next_state = CMPL;
            WR_REQ:  if (wr_req_ready) next_state = WR_WAIT;
            WR_WAIT: if (wr_rsp_valid) next_state = CMPL;
            CMPL:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign rd_req_valid = (state == RD_REQ);
    assign wr_req_valid = (state == WR_REQ);
    assign busy         = (state != IDLE);
    assign data_valid   = (state == CMPL) && txn_is_read;
    assign write_done   = (state == CMPL) && !txn_is_read;

    // Base may only be replaced between transactions so an in-flight
    // request never sees its address change.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_line         <= '0;
            buffer_addr_valid <= 1'b0;
        end else if (cfg_base_valid && state == IDLE) begin
            base_line         <= cfg_base_addr[63:6];
            buffer_addr_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_req_addr <= '0;
            wr_req_addr <= '0;
            wr_req_data <= '0;
            txn_is_read <= 1'b0;
        end else if (start_read) begin
            rd_req_addr <= host_line;
            txn_is_read <= 1'b1;
        end else if (start_write) begin
            wr_req_addr <= host_line;
            wr_req_data <= write_data;
            txn_is_read <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (state == RD_WAIT && rd_rsp_valid) begin
            read_data <= rd_rsp_data;
        end
    end

    // A response counts only in its own wait state; anything else is stray.
    always_ff @(posedge clk) begin
        if (rst) begin
            stray_rsp <= 1'b0;
        end else if ((rd_rsp_valid && state != RD_WAIT) ||
                     (wr_rsp_valid && state != WR_WAIT)) begin
            stray_rsp <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == CMPL) begin
            if (txn_is_read) begin
                rd_count <= rd_count + 32'd1;
            end else begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_host_bridge.sv
// Scoreboard bench for mem_host_bridge: expected host requests and completions
// are queued when a request is applied and retired by a negedge monitor.
module tb_mem_host_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_base_valid;
    logic [63:0]  cfg_base_addr;
    logic [31:0]  address;
    logic [511:0] write_data;
    logic         read_request_valid;
    logic         write_request_valid;
    logic         buffer_addr_valid;
    logic         data_valid;
    logic [511:0] read_data;
    logic         write_done;
    logic         rd_req_valid;
    logic [57:0]  rd_req_addr;
    logic         rd_req_ready;
    logic         rd_rsp_valid;
    logic [511:0] rd_rsp_data;
    logic         wr_req_valid;
    logic [57:0]  wr_req_addr;
    logic [511:0] wr_req_data;
    logic         wr_req_ready;
    logic         wr_rsp_valid;
    logic         busy;
    logic         stray_rsp;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;

    typedef struct {
        logic         isWrite;
        logic [57:0]  addr;
        logic [511:0] data;
    } txn_t;

    txn_t         sb[$];
    logic [57:0]  modelBase;
    int           checkCount = 0;
    int           errorCount = 0;

    mem_host_bridge dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_base_valid     (cfg_base_valid),
        .cfg_base_addr      (cfg_base_addr),
        .address            (address),
        .write_data         (write_data),
        .read_request_valid (read_request_valid),
        .write_request_valid(write_request_valid),
        .buffer_addr_valid  (buffer_addr_valid),
        .data_valid         (data_valid),
        .read_data          (read_data),
        .write_done         (write_done),
        .rd_req_valid       (rd_req_valid),
        .rd_req_addr        (rd_req_addr),
        .rd_req_ready       (rd_req_ready),
        .rd_rsp_valid       (rd_rsp_valid),
        .rd_rsp_data        (rd_rsp_data),
        .wr_req_valid       (wr_req_valid),
        .wr_req_addr        (wr_req_addr),
        .wr_req_data        (wr_req_data),
        .wr_req_ready       (wr_req_ready),
        .wr_rsp_valid       (wr_rsp_valid),
        .busy               (busy),
        .stray_rsp          (stray_rsp),
        .rd_count           (rd_count),
        .wr_count           (wr_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [511:0] actual,
                               input logic [511:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual[63:0], expected[63:0]);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Drive a control-unit request and queue what the host side should see.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [511:0] wdata, input logic [511:0] rdata);
        txn_t t;
        if (rd) begin
            t.isWrite = 1'b0;
            t.addr    = modelBase + {26'd0, addr};
            t.data    = rdata;
            sb.push_back(t);
        end
        if (wr) begin
            t.isWrite = 1'b1;
            t.addr    = modelBase + {26'd0, addr};
            t.data    = wdata;
            sb.push_back(t);
        end
        address             = addr;
        write_data          = wdata;
        read_request_valid  = rd;
        write_request_valid = wr;
    endtask

    task automatic cfgBase(input logic [63:0] a);
        cfg_base_addr  = a;
        cfg_base_valid = 1'b1;
        modelBase      = a[63:6];
        cyc(1);
        cfg_base_valid = 1'b0;
        checkOutput("buffer_addr_valid_set", buffer_addr_valid, 1);
    endtask

    task automatic waitRdAccept();
        for (int i = 0; i < 100 && !rd_req_valid; i++) cyc(1);
        checkOutput("rd_req_seen", rd_req_valid, 1);
        rd_req_ready = 1'b1;
        cyc(1);
    endtask

    task automatic rdRespond(input logic [511:0] d, input int delay);
        repeat (delay - 1) cyc(1);
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = d;
        cyc(1);
        rd_rsp_valid = 1'b0;
        checkOutput("data_valid_high", data_valid, 1);
        checkOutput("read_data", read_data, d);
        read_request_valid = 1'b0;
        cyc(1);
        checkOutput("data_valid_one_cycle", data_valid, 0);
        checkOutput("read_data_held", read_data, d);
    endtask

    task automatic waitWrAccept();
        for (int i = 0; i < 100 && !wr_req_valid; i++) cyc(1);
        checkOutput("wr_req_seen", wr_req_valid, 1);
        wr_req_ready = 1'b1;
        cyc(1);
    endtask

    task automatic wrRespond(input int delay);
        repeat (delay - 1) cyc(1);
        wr_rsp_valid = 1'b1;
        cyc(1);
        wr_rsp_valid = 1'b0;
        checkOutput("write_done_high", write_done, 1);
        write_request_valid = 1'b0;
        cyc(1);
        checkOutput("write_done_one_cycle", write_done, 0);
    endtask

    // Scoreboard monitor: host request contents and completion pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_req_valid && rd_req_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_empty_rd_req", rd_req_valid, 0);
                end else begin
                    checkOutput("rd_req_kind", sb[0].isWrite, 0);
                    checkOutput("rd_req_addr", rd_req_addr, sb[0].addr);
                end
            end
            if (wr_req_valid && wr_req_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_empty_wr_req", wr_req_valid, 0);
                end else begin
                    checkOutput("wr_req_kind", sb[0].isWrite, 1);
                    checkOutput("wr_req_addr", wr_req_addr, sb[0].addr);
                    checkOutput("wr_req_data", wr_req_data, sb[0].data);
                end
            end
            if (data_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_empty_data_valid", data_valid, 0);
                end else begin
                    checkOutput("cmpl_kind_read", sb[0].isWrite, 0);
                    checkOutput("sb_read_data", read_data, sb[0].data);
                    void'(sb.pop_front());
                end
            end
            if (write_done) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_empty_write_done", write_done, 0);
                end else begin
                    checkOutput("cmpl_kind_write", sb[0].isWrite, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [511:0] d;
        logic [511:0] w;
        rst = 1'b1;
        cfg_base_valid = 1'b0;
        cfg_base_addr = '0;
        address = '0;
        write_data = '0;
        read_request_valid = 1'b0;
        write_request_valid = 1'b0;
        rd_req_ready = 1'b1;
        rd_rsp_valid = 1'b0;
        rd_rsp_data = '0;
        wr_req_ready = 1'b1;
        wr_rsp_valid = 1'b0;
        modelBase = '0;
        cyc(3);
        rst = 1'b0;
        checkOutput("rst_buffer_addr_valid", buffer_addr_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rd_req_valid", rd_req_valid, 0);
        checkOutput("rst_wr_req_valid", wr_req_valid, 0);
        checkOutput("rst_stray", stray_rsp, 0);
        checkOutput("rst_rd_count", rd_count, 0);
        checkOutput("rst_wr_count", wr_count, 0);
        checkOutput("rst_read_data", read_data, 0);
        checkOutput("rst_rd_req_addr", rd_req_addr, 0);
        checkOutput("rst_wr_req_data", wr_req_data, 0);

        // Request before any base is configured is ignored, then serviced.
        d = {64{8'hA5}};
        applyStimulus(1'b1, 1'b0, 32'd3, '0, d);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            checkOutput("nobase_busy", busy, 0);
            checkOutput("nobase_rd_req_valid", rd_req_valid, 0);
        end
        sb[0].addr = 58'h43;
        cfgBase(64'h1000);
        cyc(1);
        checkOutput("rd_req_latency", rd_req_valid, 1);
        checkOutput("rd_req_addr_0x43", rd_req_addr, 58'h43);
        waitRdAccept();
        rdRespond(d, 4);
        checkOutput("rd_count_1", rd_count, 1);

        // Host holds off acceptance for ten cycles.
        rd_req_ready = 1'b0;
        d = rnd512();
        applyStimulus(1'b1, 1'b0, 32'd5, '0, d);
        for (int i = 0; i < 10 && !rd_req_valid; i++) cyc(1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_rd_req_valid", rd_req_valid, 1);
            checkOutput("stall_rd_req_addr", rd_req_addr, 58'h45);
            if (i < 9) cyc(1);
        end
        waitRdAccept();
        rdRespond(d, 2);
        checkOutput("rd_count_2", rd_count, 2);

        // Simultaneous read and write: read goes first.
        d = rnd512();
        w = rnd512();
        applyStimulus(1'b1, 1'b1, 32'h100, w, d);
        waitRdAccept();
        rdRespond(d, 3);
        waitWrAccept();
        wrRespond(2);
        checkOutput("rd_count_3", rd_count, 3);
        checkOutput("wr_count_1", wr_count, 1);

        // Host address wraps modulo 2^58; base pulse while busy is ignored.
        cfgBase(64'hFFFF_FFFF_FFFF_FFFF);
        w = rnd512();
        applyStimulus(1'b0, 1'b1, 32'd2, w, '0);
        waitWrAccept();
        cfg_base_addr  = 64'h0;
        cfg_base_valid = 1'b1;
        cyc(1);
        cfg_base_valid = 1'b0;
        wrRespond(2);
        checkOutput("wr_count_2", wr_count, 2);
        d = rnd512();
        applyStimulus(1'b1, 1'b0, 32'd0, '0, d);
        waitRdAccept();
        checkOutput("base_kept_addr", rd_req_addr, 58'h3FF_FFFF_FFFF_FFFF);
        rdRespond(d, 1);
        checkOutput("rd_count_4", rd_count, 4);

        // Write response while idle is stray and sticky until reset.
        wr_rsp_valid = 1'b1;
        cyc(1);
        wr_rsp_valid = 1'b0;
        checkOutput("stray_set", stray_rsp, 1);
        checkOutput("stray_no_write_done", write_done, 0);
        checkOutput("stray_idle", busy, 0);
        cyc(3);
        checkOutput("stray_sticky", stray_rsp, 1);
        checkOutput("stray_wr_count", wr_count, 2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        checkOutput("stray_cleared", stray_rsp, 0);
        checkOutput("rst_clears_base_valid", buffer_addr_valid, 0);

        // Reset in RD_WAIT abandons the read; late response is stray.
        cfgBase(64'h2000);
        d = rnd512();
        applyStimulus(1'b1, 1'b0, 32'd7, '0, d);
        waitRdAccept();
        checkOutput("in_rd_wait_busy", busy, 1);
        rst = 1'b1;
        read_request_valid = 1'b0;
        sb.delete();
        cyc(1);
        rst = 1'b0;
        cyc(1);
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = d;
        cyc(1);
        rd_rsp_valid = 1'b0;
        checkOutput("late_rsp_no_data_valid", data_valid, 0);
        cyc(2);
        checkOutput("late_rsp_rd_count", rd_count, 0);
        checkOutput("late_rsp_stray", stray_rsp, 1);
        checkOutput("late_rsp_base_valid", buffer_addr_valid, 0);
        checkOutput("late_rsp_read_data", read_data, 0);
        checkOutput("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
